// File: rtl/sprite_draw_scheduler.sv
// Shares one VGA plot port among several sprite controllers. Each granted move
// runs a clear pass at the old position, then a shifted draw pass.
module sprite_draw_scheduler #(
  parameter int NUM_SPRITES = 4,
  parameter int PIXELS      = 256,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int COL_W       = 12
) (
  input  logic                              i_clk,
  input  logic                              i_resetn,
  input  logic                              i_hold,
  input  logic [NUM_SPRITES-1:0]            i_req,
  input  logic [NUM_SPRITES-1:0]            i_req_vert,
  input  logic [7*NUM_SPRITES-1:0]          i_req_amount,
  output logic [NUM_SPRITES-1:0]            o_ack,
  output logic                              o_busy,
  output logic [$clog2(NUM_SPRITES)-1:0]    o_grant_id,
  output logic [NUM_SPRITES-1:0]            o_spr_draw,
  output logic [NUM_SPRITES-1:0]            o_spr_clear,
  output logic [NUM_SPRITES-1:0]            o_spr_shift_h,
  output logic [NUM_SPRITES-1:0]            o_spr_shift_v,
  output logic [6:0]                        o_spr_shift_amount,
  input  logic [X_W*NUM_SPRITES-1:0]        i_spr_x,
  input  logic [Y_W*NUM_SPRITES-1:0]        i_spr_y,
  input  logic [COL_W*NUM_SPRITES-1:0]      i_spr_colour,
  output logic [X_W-1:0]                    o_vga_x,
  output logic [Y_W-1:0]                    o_vga_y,
  output logic [COL_W-1:0]                  o_vga_colour,
  output logic                              o_vga_plot
);

  localparam int IDX_W = $clog2(NUM_SPRITES);
  localparam int CNT_W = $clog2(PIXELS);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_CLEAR, S_GAP, S_DRAW, S_ACK
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_rr_last;
  logic [IDX_W-1:0]   r_grant;
  logic [6:0]         r_amount;
  logic               r_vert;

  logic [IDX_W-1:0]   w_sel;
  logic               w_any;
  logic               w_last_pix;
  logic [NUM_SPRITES-1:0] w_onehot;

  // Walk from the lowest-priority slot (rr_last) towards the highest so the
  // slot nearest to rr_last+1 is the one that sticks.
  always_comb begin
    w_sel = '0;
    w_any = 1'b0;
    for (int k = NUM_SPRITES; k >= 1; k--) begin
      if (i_req[(int'(r_rr_last) + k) % NUM_SPRITES]) begin
        w_sel = IDX_W'((int'(r_rr_last) + k) % NUM_SPRITES);
        w_any = 1'b1;
      end
    end
  end

  assign w_last_pix = (r_cnt == CNT_W'(PIXELS - 1));
  assign w_onehot   = NUM_SPRITES'(1) << r_grant;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!i_hold && w_any) w_next = S_GRANT;
      S_GRANT: w_next = S_CLEAR;
      S_CLEAR: if (w_last_pix) w_next = S_GAP;
      S_GAP:   w_next = S_DRAW;
      S_DRAW:  if (w_last_pix) w_next = S_ACK;
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rr_last <= IDX_W'(NUM_SPRITES - 1);
      r_grant   <= '0;
      r_amount  <= '0;
      r_vert    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_next == S_GRANT) begin
        r_grant  <= w_sel;
        r_amount <= i_req_amount[7*w_sel +: 7];
        r_vert   <= i_req_vert[w_sel];
      end
      if (r_state == S_GRANT) r_rr_last <= r_grant;
      // Counter wraps to 0 on the last pixel, ready for the next pass.
      if (r_state == S_CLEAR || r_state == S_DRAW) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    o_ack              = '0;
    o_busy             = (r_state != S_IDLE);
    o_grant_id         = r_grant;
    o_spr_draw         = '0;
    o_spr_clear        = '0;
    o_spr_shift_h      = '0;
    o_spr_shift_v      = '0;
    o_spr_shift_amount = '0;
    o_vga_plot         = 1'b0;
    case (r_state)
      S_CLEAR: begin
        o_spr_draw  = w_onehot;
        o_spr_clear = w_onehot;
        o_vga_plot  = 1'b1;
      end
      S_DRAW: begin
        o_spr_draw         = w_onehot;
        o_spr_shift_v      = r_vert ? w_onehot : '0;
        o_spr_shift_h      = r_vert ? '0 : w_onehot;
        o_spr_shift_amount = r_amount;
        o_vga_plot         = 1'b1;
      end
      S_ACK:   o_ack = w_onehot;
      default: ;
    endcase
  end

  always_comb begin
    o_vga_x      = '0;
    o_vga_y      = '0;
    o_vga_colour = '0;
    if (o_vga_plot) begin
      o_vga_x      = i_spr_x[X_W*r_grant +: X_W];
      o_vga_y      = i_spr_y[Y_W*r_grant +: Y_W];
      o_vga_colour = i_spr_colour[COL_W*r_grant +: COL_W];
    end
  end

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Bench for sprite_draw_scheduler: directed and randomized moves checked
// cycle by cycle against a phase-timeline / round-robin reference model.
module tb_sprite_draw_scheduler;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        hold = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  req_vert = '0;
  logic [27:0] req_amount = '0;
  logic [3:0]  ack, spr_draw, spr_clear, spr_shift_h, spr_shift_v;
  logic        busy, vga_plot;
  logic [1:0]  grant_id;
  logic [6:0]  spr_shift_amount;
  logic [31:0] spr_x = '0;
  logic [27:0] spr_y = '0;
  logic [47:0] spr_colour = '0;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [11:0] vga_colour;

  int checks = 0;
  int errors = 0;
  int rr_last = 3;
  logic [1:0] last_gid = '0;

  always #5 clk = ~clk;

  sprite_draw_scheduler dut (
    .i_clk(clk), .i_resetn(resetn), .i_hold(hold),
    .i_req(req), .i_req_vert(req_vert), .i_req_amount(req_amount),
    .o_ack(ack), .o_busy(busy), .o_grant_id(grant_id),
    .o_spr_draw(spr_draw), .o_spr_clear(spr_clear),
    .o_spr_shift_h(spr_shift_h), .o_spr_shift_v(spr_shift_v),
    .o_spr_shift_amount(spr_shift_amount),
    .i_spr_x(spr_x), .i_spr_y(spr_y), .i_spr_colour(spr_colour),
    .o_vga_x(vga_x), .o_vga_y(vga_y), .o_vga_colour(vga_colour),
    .o_vga_plot(vga_plot)
  );

  function automatic logic [63:0] pack_obs();
    return {6'b0, busy, grant_id, ack, spr_draw, spr_clear, spr_shift_h,
            spr_shift_v, spr_shift_amount, vga_plot, vga_x, vga_y, vga_colour};
  endfunction

  function automatic logic [63:0] pack_exp(input logic b, input logic [1:0] gid,
      input logic [3:0] a, input logic [3:0] d, input logic [3:0] c,
      input logic [3:0] h, input logic [3:0] v, input logic [6:0] am,
      input logic p, input logic [7:0] x, input logic [6:0] y, input logic [11:0] col);
    return {6'b0, b, gid, a, d, c, h, v, am, p, x, y, col};
  endfunction

  function automatic logic [63:0] idle_exp();
    return pack_exp(1'b0, last_gid, '0, '0, '0, '0, '0, '0, 1'b0, '0, '0, '0);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic new_pixels(input bit fixed_col);
    spr_x = $urandom;
    spr_y = 28'($urandom);
    if (fixed_col) spr_colour = {12'h0AB, 12'hF00, 12'h0AB, 12'h0AB};
    else           spr_colour = {16'($urandom), $urandom};
  endtask

  // Round-robin rule: first requester after the last served slot.
  function automatic int pick(input logic [3:0] r);
    for (int k = 1; k <= 4; k++)
      if (r[(rr_last + k) % 4]) return (rr_last + k) % 4;
    return -1;
  endfunction

  // Called #1 after a posedge while the DUT is idle. Follows one move from
  // GRANT (k=0) to ACK (k=514) and returns #1 after the edge leaving ACK.
  task automatic serve(input int g, input int max_wait, input int exp_wait,
                       input bit hold_draw, input bit fixed_col);
    logic       dir;
    logic [6:0] am;
    logic [3:0] oh;
    logic [1:0] gid;
    logic [63:0] e;
    int w;
    bit got;
    dir = req_vert[g];
    am  = req_amount[7*g +: 7];
    oh  = 4'(1) << g;
    gid = 2'(g);
    got = 1'b0;
    new_pixels(fixed_col);
    for (w = 0; w <= max_wait; w++) begin
      @(negedge clk);
      if (busy === 1'b1) begin got = 1'b1; break; end
      check("idle_wait", pack_obs(), idle_exp());
      @(posedge clk); #1;
    end
    if (!got) begin
      checks++; errors++;
      $error("FAIL grant_timeout slot=%0d observed_busy=0 expected_busy=1", g);
      return;
    end
    if (exp_wait >= 0) check("idle_len", 64'(w), 64'(exp_wait));
    for (int k = 0; k <= 514; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 0 || k == 257)
        e = pack_exp(1'b1, gid, '0, '0, '0, '0, '0, '0, 1'b0, '0, '0, '0);
      else if (k <= 256)
        e = pack_exp(1'b1, gid, '0, oh, oh, '0, '0, '0, 1'b1,
                     spr_x[8*g +: 8], spr_y[7*g +: 7], spr_colour[12*g +: 12]);
      else if (k <= 513)
        e = pack_exp(1'b1, gid, '0, oh, '0, dir ? 4'b0 : oh, dir ? oh : 4'b0, am, 1'b1,
                     spr_x[8*g +: 8], spr_y[7*g +: 7], spr_colour[12*g +: 12]);
      else
        e = pack_exp(1'b1, gid, oh, '0, '0, '0, '0, '0, 1'b0, '0, '0, '0);
      check($sformatf("move_s%0d_k%0d", g, k), pack_obs(), e);
      if (fixed_col && k >= 1 && k <= 513 && k != 257)
        check($sformatf("mux_colour_k%0d", k), 64'(vga_colour), 64'(12'hF00));
      @(posedge clk); #1;
      new_pixels(fixed_col);
      if (k == 5) begin
        req_amount[7*g +: 7] = 7'($urandom);
        req_vert[g] = 1'($urandom);
      end
      if (k == 10) req[g] = 1'b0;
      if (hold_draw && k == 300) hold = 1'b1;
    end
    rr_last  = g;
    last_gid = gid;
  endtask

  task automatic set_slot(input int s, input logic v, input logic [6:0] am);
    req_vert[s] = v;
    req_amount[7*s +: 7] = am;
    req[s] = 1'b1;
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, pack_obs(), idle_exp());
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    #1;
    rr_last = 3; last_gid = '0;
    check("reset_async", pack_obs(), idle_exp());
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  initial begin
    int g;
    bit got;
    new_pixels(1'b0);
    #2;
    check("reset_state", pack_obs(), idle_exp());
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b1;

    // Single horizontal move, amount 5.
    set_slot(0, 1'b0, 7'd5);
    serve(0, 2, 1, 1'b0, 1'b0);
    idle_cycles(2, "after_single");

    // Round robin from reset: 0,1,2,3; slot 3 vertical with amount 127.
    pulse_reset();
    set_slot(0, 1'b0, 7'($urandom));
    set_slot(1, 1'b1, 7'($urandom));
    set_slot(2, 1'b0, 7'd0);
    set_slot(3, 1'b1, 7'h7F);
    serve(0, 2, 1, 1'b0, 1'b0);
    serve(1, 2, 1, 1'b0, 1'b0);
    serve(2, 2, 1, 1'b0, 1'b0);
    serve(3, 2, 1, 1'b0, 1'b0);
    set_slot(0, 1'b0, 7'($urandom));
    set_slot(1, 1'b0, 7'($urandom));
    serve(0, 2, 1, 1'b0, 1'b0);
    serve(1, 2, 1, 1'b0, 1'b0);
    set_slot(0, 1'b1, 7'($urandom));
    set_slot(2, 1'b0, 7'($urandom));
    serve(2, 2, 1, 1'b0, 1'b1);
    serve(0, 2, 1, 1'b0, 1'b0);

    // hold blocks grants; hold raised mid-draw does not stop the move.
    hold = 1'b1;
    set_slot(1, 1'b0, 7'd33);
    idle_cycles(8, "hold_idle");
    hold = 1'b0;
    serve(1, 1, 1, 1'b1, 1'b0);
    set_slot(3, 1'b1, 7'd9);
    idle_cycles(6, "hold_after_ack");
    hold = 1'b0;
    serve(3, 1, 1, 1'b0, 1'b0);

    // Randomized request traffic against the round-robin model.
    for (int it = 0; it < 14; it++) begin
      for (int s = 0; s < 4; s++)
        if (!req[s] && $urandom_range(1, 0) == 1) set_slot(s, 1'($urandom), 7'($urandom));
      if (req == 4'b0) begin
        g = $urandom_range(3, 0);
        set_slot(g, 1'($urandom), 7'($urandom));
      end
      g = pick(req);
      serve(g, 2, 1, 1'b0, 1'b0);
    end
    req = '0;
    idle_cycles(2, "random_drain");

    // Reset at CLEAR pixel 100, then a fresh move from slot 0.
    set_slot(2, 1'b0, 7'd3);
    got = 1'b0;
    for (int w = 0; w < 10; w++) begin
      @(negedge clk);
      if (busy === 1'b1) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!got) begin
      checks++; errors++;
      $error("FAIL reset_test_grant_timeout observed_busy=0 expected_busy=1");
    end
    for (int i = 0; i < 101; i++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("clear_px100_plot", 64'({vga_plot, spr_clear}), 64'({1'b1, 4'b0100}));
    @(posedge clk); #1;
    req = '0;
    resetn = 1'b0;
    #1;
    rr_last = 3; last_gid = '0;
    check("reset_mid_pass", pack_obs(), idle_exp());
    idle_cycles(3, "in_reset");
    resetn = 1'b1;
    idle_cycles(3, "post_reset_no_ack");
    set_slot(0, 1'b1, 7'd77);
    serve(0, 2, 1, 1'b0, 1'b0);
    idle_cycles(2, "final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sprite_draw_scheduler.md
Name: sprite_draw_scheduler

Overview:
- Time-shares the single VGA plot port among NUM_SPRITES sprite controllers that each stream one 16x16 sprite (256 pixels, one per clock while draw is high).
- Accepts per-sprite move requests and arbitrates them round-robin.
- For each granted request it runs a clear pass at the old position, then a shifted draw pass.
- Muxes the granted sprite's pixel stream onto the VGA adapter write interface.

Parameters:
- NUM_SPRITES, 4, number of sprite controllers; index width is 2.
- PIXELS, 256, pixels per pass; pixel counter width 8.
- X_W, 8, VGA x width.
- Y_W, 7, VGA y width.
- COL_W, 12, colour width.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- resetn  in  1  asynchronous active-low reset.
- hold  in  1  when high, no new grant is issued; an in-progress move completes.
- req  in  NUM_SPRITES  per-sprite move request; level, held until ack.
- req_vert  in  NUM_SPRITES  per-sprite direction; 0 = shift_h, 1 = shift_v.
- req_amount  in  7*NUM_SPRITES  per-sprite shift amount; slot i occupies bits [7i+6:7i].
- ack  out  NUM_SPRITES  one-cycle pulse on completion of slot i's move.
- busy  out  1  high in every state except IDLE.
- grant_id  out  2  index of the current/last granted slot.
- spr_draw  out  NUM_SPRITES  draw enable, one-hot to the granted slot.
- spr_clear  out  NUM_SPRITES  clear select, one-hot.
- spr_shift_h  out  NUM_SPRITES  horizontal shift select, one-hot.
- spr_shift_v  out  NUM_SPRITES  vertical shift select, one-hot.
- spr_shift_amount  out  7  latched amount, shared by all sprites.
- spr_x  in  X_W*NUM_SPRITES  x_out of each sprite controller.
- spr_y  in  Y_W*NUM_SPRITES  y_out of each sprite controller.
- spr_colour  in  COL_W*NUM_SPRITES  colour_out of each sprite controller.
- vga_x  out  X_W  muxed pixel x.
- vga_y  out  Y_W  muxed pixel y.
- vga_colour  out  COL_W  muxed pixel colour.
- vga_plot  out  1  write enable to the VGA adapter.

Behaviour:
- Reset (async, resetn = 0):
  - state = IDLE; pixel counter = 0; rr_last = NUM_SPRITES-1, so slot 0 has first priority.
  - All spr_* outputs, ack, busy, vga_plot, grant_id and latched amount/direction = 0.
- States: IDLE -> GRANT -> CLEAR -> GAP -> DRAW -> ACK -> IDLE.
- IDLE:
  - If hold = 0 and any req is high, select the first requesting slot searching rr_last+1, rr_last+2, ... (mod NUM_SPRITES).
  - Latch the slot index, its req_vert and its req_amount; go to GRANT.
- GRANT (1 cycle): outputs idle; grant_id valid; rr_last = granted slot.
- CLEAR (exactly PIXELS cycles):
  - spr_draw[g] = spr_clear[g] = 1; vga_plot = 1.
  - Pixel counter increments each cycle. Exit when the counter wraps 255 -> 0.
- GAP (1 cycle): all spr_* = 0 and vga_plot = 0, so the sprite's pointer-wrap completion settles.
- DRAW (exactly PIXELS cycles):
  - spr_draw[g] = 1; spr_shift_v[g] = latched dir, or spr_shift_h[g] = !dir.
  - spr_shift_amount = latched amount; vga_plot = 1. Counter wraps as in CLEAR.
- ACK (1 cycle): ack[g] = 1, then return to IDLE. The requester must drop req or present a new request.
- Pixel mux: vga_x/y/colour = spr_x/y/colour of slot g, combinational from the inputs, valid whenever vga_plot = 1. Outputs are 0 otherwise.
- Timing:
  - Grant-to-ack latency = 1 + 256 + 1 + 256 = 514 cycles after the IDLE decision cycle.
  - Back-to-back service is possible: IDLE lasts 1 cycle between moves.
- Latched values: req_amount/req_vert changes after GRANT have no effect. req deassertion mid-move does not abort the move.
- hold:
  - Sampled only in IDLE; hold high mid-move is ignored until ACK.
  - busy stays 0 while held with pending requests.
- Simultaneous requests: strict round-robin. A slot is never served twice while another slot has a continuously pending request.
- Amount 0: still performs the full clear and draw passes; no special case.
- Reset mid-pass: outputs drop to 0 immediately (async); no ack is issued for that move. Sprite controllers are resynchronised by the system reset.

Test Plan:
- Single request: req = 0001, amount = 5, vert = 0 -> GRANT, then 256 cycles with spr_clear[0] = 1 and vga_plot = 1, 1 gap cycle, then 256 cycles with spr_shift_h[0] = 1 and amount = 5; ack[0] pulses exactly 514 cycles after grant.
- Round-robin: req = 1111 held, each dropped on its ack -> grant order 0,1,2,3. Re-asserting 0 and 2 after slot 1's ack -> order 2 then 0.
- Vertical move: slot 3, vert = 1, amount = 127 -> spr_shift_v[3] = 1, spr_shift_h = 0, spr_shift_amount = 7'h7F throughout DRAW.
- Mux: drive spr_colour slot 2 = 12'hF00, others 12'h0AB -> vga_colour = 12'hF00 whenever vga_plot = 1 during slot 2's service; 0 when vga_plot = 0.
- hold: hold = 1 with req = 0010 -> busy = 0, no grant. hold = 0 -> grant next cycle. Hold raised during DRAW -> move completes and acks.
- Reset at CLEAR pixel 100 -> all outputs 0 within the same cycle; after release, req = 0001 -> fresh 514-cycle sequence from slot 0.
